// File: rtl/dtc_pkg.sv
// Shared DTC link constants and parser state encoding, common to the
// receive deframer and the transmitter.
package dtc_pkg;

  localparam logic [15:0] SYNC       = 16'hBC50;
  localparam logic [15:0] REPLY_HDR  = 16'hF7F7;
  localparam logic [15:0] STATUS_HDR = 16'hDCDC;
  localparam logic [15:0] EVENT_HDR  = 16'h5C5C;
  localparam logic [15:0] TRAILER    = 16'hC5D5;

  typedef enum logic [3:0] {
    IDLE,
    ST_WORD,
    RP_AH,
    RP_AL,
    RP_DH,
    RP_DL,
    EV_ADC,
    EV_TDC,
    EV_TRL
  } parser_state_e;

endpackage

// File: rtl/dtc_rx_deframer_if.sv
// Nibble input and decoded-output bundle of the DTC receive deframer.
interface dtc_rx_deframer_if;
  logic [3:0]  dtc_nibble;
  logic        locked;
  logic        status_vld;
  logic [15:0] status;
  logic        reply_vld;
  logic [31:0] reply_addr;
  logic [31:0] reply_data;
  logic        adc_vld;
  logic [11:0] adc_word;
  logic [5:0]  adc_ch;
  logic [5:0]  adc_sample;
  logic        event_start;
  logic        event_done;
  logic        event_err;
  logic [15:0] err_cnt;

  modport master (
    output dtc_nibble,
    input  locked, status_vld, status, reply_vld, reply_addr, reply_data,
    input  adc_vld, adc_word, adc_ch, adc_sample,
    input  event_start, event_done, event_err, err_cnt
  );

  modport slave (
    input  dtc_nibble,
    output locked, status_vld, status, reply_vld, reply_addr, reply_data,
    output adc_vld, adc_word, adc_ch, adc_sample,
    output event_start, event_done, event_err, err_cnt
  );
endinterface

// File: rtl/dtc_rx_align.sv
// Word aligner: shifts nibbles into a 16-bit window, locks onto a repeating
// SYNC phase and then emits one word every four cycles at that phase.
module dtc_rx_align
  import dtc_pkg::*;
#(
  parameter int LOCK_SYNCS = 3
) (
  input  logic        dtc_clk,
  input  logic        rst,
  input  logic [3:0]  nibble,
  input  logic        unlock,
  output logic        locked,
  output logic        word_vld,
  output logic [15:0] word
);
  localparam int CNT_W = $clog2(LOCK_SYNCS + 1);

  logic [15:0]      sr_q, sr_d, word_q, word_d;
  logic [1:0]       phase_q, phase_d, cap_q, cap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d, word_vld_q, word_vld_d;

  always_comb begin
    sr_d       = {nibble, sr_q[15:4]};
    phase_d    = phase_q + 2'd1;
    cap_d      = cap_q;
    cnt_d      = cnt_q;
    locked_d   = locked_q;
    word_vld_d = 1'b0;
    word_d     = word_q;
    if (unlock) begin
      locked_d = 1'b0;
      cnt_d    = '0;
    end else if (locked_q) begin
      if (phase_q == cap_q) begin
        word_vld_d = 1'b1;
        word_d     = sr_q;
      end
    end else if (cnt_q != '0 && phase_q == cap_q) begin
      // A miss at the candidate phase keeps the phase but restarts the run.
      if (sr_q == SYNC) begin
        if (cnt_q == CNT_W'(LOCK_SYNCS - 1)) begin
          locked_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = CNT_W'(1);
      end
    end else if (sr_q == SYNC) begin
      cap_d = phase_q;
      cnt_d = CNT_W'(1);
    end
  end

  always_ff @(posedge dtc_clk) begin
    sr_q   <= sr_d;
    word_q <= word_d;
    if (rst) begin
      phase_q    <= '0;
      cap_q      <= '0;
      cnt_q      <= '0;
      locked_q   <= 1'b0;
      word_vld_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      cap_q      <= cap_d;
      cnt_q      <= cnt_d;
      locked_q   <= locked_d;
      word_vld_q <= word_vld_d;
    end
  end

  assign locked   = locked_q;
  assign word_vld = word_vld_q;
  assign word     = word_q;
endmodule

// File: rtl/dtc_rx_deframer.sv
// DTC receive deframer: aligns the nibble stream and parses status, register
// reply and ADC event frames into registered strobes.
module dtc_rx_deframer
  import dtc_pkg::*;
#(
  parameter int N_CH        = 64,
  parameter int N_SAMPLES   = 40,
  parameter int LOCK_SYNCS  = 3,
  parameter int UNLOCK_BAD  = 8,
  parameter int TRAILER_MAX = 8
) (
  input  logic              dtc_clk,
  input  logic              rst,
  dtc_rx_deframer_if.slave  bus
);
  localparam int BAD_W = $clog2(UNLOCK_BAD + 1);
  localparam int TRL_W = $clog2(TRAILER_MAX + 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        locked, word_vld, unlock, act;
  logic [15:0] word;

  dtc_rx_align #(.LOCK_SYNCS(LOCK_SYNCS)) u_align (
    .dtc_clk (dtc_clk),
    .rst     (rst),
    .nibble  (bus.dtc_nibble),
    .unlock  (unlock),
    .locked  (locked),
    .word_vld(word_vld),
    .word    (word)
  );

  parser_state_e    state_q, state_d;
  logic [BAD_W-1:0] bad_q, bad_d;
  logic [TRL_W-1:0] trl_q, trl_d;
  logic [5:0]       ch_q, ch_d, smp_q, smp_d, adc_ch_q, adc_ch_d, adc_smp_q, adc_smp_d;
  logic [15:0]      err_q, err_d, status_q, status_d;
  logic [11:0]      adc_word_q, adc_word_d;
  logic [31:0]      acc_addr_q, acc_addr_d, rp_addr_q, rp_addr_d, rp_data_q, rp_data_d;
  logic [15:0]      acc_data_q, acc_data_d;
  logic             ev_err_q, ev_err_d, status_vld_q, status_vld_d, reply_vld_q, reply_vld_d;
  logic             adc_vld_q, adc_vld_d, start_q, start_d, done_q, done_d, everr_q, everr_d;

  assign act = word_vld && locked;

  always_comb begin
    state_d = state_q;  bad_d = bad_q;  trl_d = trl_q;  err_d = err_q;
    ch_d = ch_q;  smp_d = smp_q;  ev_err_d = ev_err_q;
    adc_ch_d = adc_ch_q;  adc_smp_d = adc_smp_q;  adc_word_d = adc_word_q;
    status_d = status_q;  rp_addr_d = rp_addr_q;  rp_data_d = rp_data_q;
    acc_addr_d = acc_addr_q;  acc_data_d = acc_data_q;
    status_vld_d = 1'b0;  reply_vld_d = 1'b0;  adc_vld_d = 1'b0;
    start_d = 1'b0;  done_d = 1'b0;  everr_d = 1'b0;  unlock = 1'b0;
    if (!locked && state_q != IDLE) begin
      // Lock lost mid-frame: drop partial results, flag only open events.
      state_d = IDLE;
      everr_d = state_q inside {EV_ADC, EV_TDC, EV_TRL};
    end else if (act) begin
      case (state_q)
        IDLE: begin
          bad_d = '0;
          if (word == STATUS_HDR)     state_d = ST_WORD;
          else if (word == REPLY_HDR) state_d = RP_AH;
          else if (word == EVENT_HDR) begin
            state_d  = EV_ADC;
            start_d  = 1'b1;
            ch_d     = 6'(N_CH - 1);
            smp_d    = 6'(N_SAMPLES - 1);
            ev_err_d = 1'b0;
          end else if (word != SYNC) begin
            err_d = sat_inc(err_q);
            if (bad_q == BAD_W'(UNLOCK_BAD - 1)) unlock = 1'b1;
            else                                  bad_d  = bad_q + BAD_W'(1);
          end
        end
        ST_WORD: begin
          status_d = word;  status_vld_d = 1'b1;  state_d = IDLE;
        end
        RP_AH: begin acc_addr_d[31:16] = word;  state_d = RP_AL; end
        RP_AL: begin acc_addr_d[15:0]  = word;  state_d = RP_DH; end
        RP_DH: begin acc_data_d        = word;  state_d = RP_DL; end
        RP_DL: begin
          rp_addr_d = acc_addr_q;  rp_data_d = {acc_data_q, word};
          reply_vld_d = 1'b1;  state_d = IDLE;
        end
        EV_ADC: begin
          adc_vld_d = 1'b1;  adc_word_d = word[11:0];
          adc_ch_d  = ch_q;  adc_smp_d  = smp_q;
          if (word[15:12] != 4'h0) begin
            ev_err_d = 1'b1;  err_d = sat_inc(err_q);
          end
          if (ch_q == 6'd0 && smp_q == 6'd0) state_d = EV_TDC;
          else if (smp_q == 6'd0) begin
            smp_d = 6'(N_SAMPLES - 1);  ch_d = ch_q - 6'd1;
          end else smp_d = smp_q - 6'd1;
        end
        EV_TDC: begin state_d = EV_TRL;  trl_d = '0; end
        EV_TRL: begin
          if (word == TRAILER) begin
            done_d = 1'b1;  everr_d = ev_err_q;  state_d = IDLE;
          end else if (trl_q == TRL_W'(TRAILER_MAX - 1)) begin
            everr_d = 1'b1;  err_d = sat_inc(err_q);  state_d = IDLE;
          end else trl_d = trl_q + TRL_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame accumulators carry no meaning outside a frame and are not reset.
  always_ff @(posedge dtc_clk) begin
    acc_addr_q <= acc_addr_d;
    acc_data_q <= acc_data_d;
  end

  always_ff @(posedge dtc_clk) begin
    if (rst) begin
      state_q <= IDLE;  bad_q <= '0;  trl_q <= '0;  err_q <= '0;
      ch_q <= '0;  smp_q <= '0;  ev_err_q <= 1'b0;
      adc_ch_q <= '0;  adc_smp_q <= '0;  adc_word_q <= '0;
      status_q <= '0;  rp_addr_q <= '0;  rp_data_q <= '0;
      status_vld_q <= 1'b0;  reply_vld_q <= 1'b0;  adc_vld_q <= 1'b0;
      start_q <= 1'b0;  done_q <= 1'b0;  everr_q <= 1'b0;
    end else begin
      state_q <= state_d;  bad_q <= bad_d;  trl_q <= trl_d;  err_q <= err_d;
      ch_q <= ch_d;  smp_q <= smp_d;  ev_err_q <= ev_err_d;
      adc_ch_q <= adc_ch_d;  adc_smp_q <= adc_smp_d;  adc_word_q <= adc_word_d;
      status_q <= status_d;  rp_addr_q <= rp_addr_d;  rp_data_q <= rp_data_d;
      status_vld_q <= status_vld_d;  reply_vld_q <= reply_vld_d;  adc_vld_q <= adc_vld_d;
      start_q <= start_d;  done_q <= done_d;  everr_q <= everr_d;
    end
  end

  assign bus.locked      = locked;
  assign bus.status_vld  = status_vld_q;
  assign bus.status      = status_q;
  assign bus.reply_vld   = reply_vld_q;
  assign bus.reply_addr  = rp_addr_q;
  assign bus.reply_data  = rp_data_q;
  assign bus.adc_vld     = adc_vld_q;
  assign bus.adc_word    = adc_word_q;
  assign bus.adc_ch      = adc_ch_q;
  assign bus.adc_sample  = adc_smp_q;
  assign bus.event_start = start_q;
  assign bus.event_done  = done_q;
  assign bus.event_err   = everr_q;
  assign bus.err_cnt     = err_q;
endmodule

// File: tb/tb_dtc_rx_deframer.sv
// Directed bench for dtc_rx_deframer: lock, status, reply, full events,
// trailer timeout, unlock/relock and reset mid-frame.
module tb_dtc_rx_deframer;
  import dtc_pkg::*;

  logic dtc_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 dtc_clk = ~dtc_clk;

  dtc_rx_deframer_if bus ();
  dtc_rx_deframer dut (.dtc_clk(dtc_clk), .rst(rst), .bus(bus));

  int n_cmp = 0, n_bad = 0;
  int status_n = 0, reply_n = 0, start_n = 0, done_n = 0, everr_n = 0;
  int adc_n = 0, adc_bad = 0;
  int exp_ch = 0, exp_s = 0, first_ch = -1, first_s = -1, last_ch = -1, last_s = -1;
  bit first_pend = 1'b0, adc_val_chk = 1'b0;
  logic [15:0] last_status = '0;
  logic [31:0] last_addr = '0, last_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor on the falling edge; reference ch/sample walk is independent.
  always @(negedge dtc_clk) begin
    if (bus.status_vld) begin status_n++; last_status = bus.status; end
    if (bus.reply_vld) begin reply_n++; last_addr = bus.reply_addr; last_data = bus.reply_data; end
    if (bus.event_done) done_n++;
    if (bus.event_err) everr_n++;
    if (bus.event_start) begin
      start_n++; exp_ch = 63; exp_s = 39; first_pend = 1'b1;
    end
    if (bus.adc_vld) begin
      adc_n++;
      if (first_pend) begin first_ch = bus.adc_ch; first_s = bus.adc_sample; first_pend = 1'b0; end
      last_ch = bus.adc_ch; last_s = bus.adc_sample;
      if (adc_val_chk && (int'(bus.adc_ch) != exp_ch || int'(bus.adc_sample) != exp_s ||
                          int'(bus.adc_word) != exp_ch * 64 + exp_s))
        adc_bad++;
      if (exp_s == 0) begin exp_s = 39; exp_ch--; end
      else exp_s--;
    end
  end

  task automatic drive_nib(input logic [3:0] n);
    bus.dtc_nibble = n;
    @(posedge dtc_clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 4; i++) drive_nib(w[4*i +: 4]);
  endtask

  task automatic send_syncs(input int n);
    for (int i = 0; i < n; i++) send_word(SYNC);
  endtask

  task automatic send_event(input logic [15:0] bad_word, input bit put_bad);
    send_word(EVENT_HDR);
    for (int c = 63; c >= 0; c--)
      for (int s = 39; s >= 0; s--)
        if (put_bad && c == 63 && s == 37) send_word(bad_word);
        else send_word(16'(c * 64 + s));
    send_word(16'h0ABC);
  endtask

  int b_status, b_reply, b_start, b_done, b_err, b_adc;

  initial begin
    bus.dtc_nibble = 4'h0;
    repeat (4) drive_nib(4'h0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    chk("rst_status_vld", bus.status_vld, 0);
    chk("rst_adc_vld", bus.adc_vld, 0);
    chk("rst_reply_data", bus.reply_data, 0);
    rst = 1'b0;

    // Scenario 1: SYNC stream at nibble offset 2
    drive_nib(4'hA);
    drive_nib(4'h3);
    send_syncs(3);
    chk("s1_locked_before", bus.locked, 0);
    drive_nib(SYNC[3:0]);
    chk("s1_locked_after", bus.locked, 1);
    drive_nib(SYNC[7:4]); drive_nib(SYNC[11:8]); drive_nib(SYNC[15:12]);
    send_syncs(2);
    chk("s1_err_cnt", bus.err_cnt, 0);

    // Scenario 2: status word
    b_status = status_n;
    send_word(STATUS_HDR);
    send_word(16'h1234);
    send_syncs(2);
    chk("s2_status_n", status_n - b_status, 1);
    chk("s2_status", last_status, 32'h1234);

    // Scenario 3: register reply
    b_reply = reply_n;
    send_word(REPLY_HDR);
    send_word(16'h0000); send_word(16'h0010);
    send_word(16'hDEAD); send_word(16'hBEEF);
    send_syncs(2);
    chk("s3_reply_n", reply_n - b_reply, 1);
    chk("s3_reply_addr", last_addr, 32'h0000_0010);
    chk("s3_reply_data", last_data, 32'hDEAD_BEEF);

    // Scenario 4: clean full event
    b_start = start_n; b_done = done_n; b_err = everr_n; b_adc = adc_n;
    adc_val_chk = 1'b1;
    send_event(16'h0000, 1'b0);
    send_word(TRAILER);
    send_syncs(2);
    adc_val_chk = 1'b0;
    chk("s4_start_n", start_n - b_start, 1);
    chk("s4_adc_n", adc_n - b_adc, 2560);
    chk("s4_adc_bad", adc_bad, 0);
    chk("s4_first_ch", first_ch, 63);
    chk("s4_first_s", first_s, 39);
    chk("s4_last_ch", last_ch, 0);
    chk("s4_last_s", last_s, 0);
    chk("s4_done_n", done_n - b_done, 1);
    chk("s4_everr_n", everr_n - b_err, 0);
    chk("s4_err_cnt", bus.err_cnt, 0);

    // Scenario 5: bad ADC nibble and missing trailer
    b_done = done_n; b_err = everr_n; b_adc = adc_n; b_status = status_n;
    send_event(16'hF005, 1'b1);
    for (int i = 0; i < 8; i++) send_word(16'h1111);
    send_syncs(1);
    chk("s5_adc_n", adc_n - b_adc, 2560);
    chk("s5_err_cnt", bus.err_cnt, 2);
    chk("s5_everr_n", everr_n - b_err, 1);
    chk("s5_done_n", done_n - b_done, 0);
    send_word(STATUS_HDR);
    send_word(16'h4321);
    send_syncs(2);
    chk("s5_idle_status_n", status_n - b_status, 1);
    chk("s5_idle_status", last_status, 32'h4321);

    // Scenario 6: bad idle words drop lock, then relock
    for (int i = 0; i < 7; i++) send_word(16'h0000);
    chk("s6_locked_7bad", bus.locked, 1);
    send_word(16'h0000);
    send_syncs(1);
    chk("s6_locked_fell", bus.locked, 0);
    chk("s6_err_cnt", bus.err_cnt, 10);
    send_syncs(6);
    chk("s6_relocked", bus.locked, 1);

    // Reset mid-event: no pulses, everything cleared
    b_err = everr_n; b_done = done_n;
    send_word(EVENT_HDR);
    send_word(16'h0001); send_word(16'h0002);
    rst = 1'b1;
    drive_nib(4'h0);
    chk("rst_mid_locked", bus.locked, 0);
    chk("rst_mid_adc_vld", bus.adc_vld, 0);
    chk("rst_mid_adc_word", bus.adc_word, 0);
    drive_nib(4'h0);
    rst = 1'b0;
    send_syncs(5);
    chk("rst_mid_everr", everr_n - b_err, 0);
    chk("rst_mid_done", done_n - b_done, 0);
    chk("rst_mid_err_cnt", bus.err_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
